// File: rtl/fetch_queue_unit.sv
// ----------------------------------------------------------------------------
// fetch_queue_unit
//   Instruction fetch stage sitting directly upstream of control_unit. Holds
//   the PC, issues sequential requests to instruction memory (at most one
//   outstanding), buffers returned instructions in a small FIFO and presents
//   the head instruction, its opcode and its PC to decode. Honours the decode
//   stall and branch redirects; a redirect flushes the queue and squashes an
//   in-flight request.
//
//   Optional feature macro: FETCH_UBR_HALT_EN
//     When defined, pushing an UBRANCH (opcode 4'b1100) parks the fetcher in
//     HALT until the next redirect, so no wrong-path requests are issued.
//
// Ports
//   clk              in   clock, rising edge
//   reset            in   asynchronous reset, active low
//   stall            in   decode stall; holds the head entry
//   redirect_valid   in   branch/flush request
//   redirect_pc      in   new fetch PC
//   imem_req_valid   out  fetch request valid
//   imem_req_addr    out  fetch address (current PC)
//   imem_req_ready   in   memory accepts request
//   imem_resp_valid  in   returned instruction valid
//   imem_resp_data   in   returned instruction
//   out_valid        out  queue head valid
//   out_instr        out  head instruction
//   out_opcode       out  head opcode (top 4 bits of out_instr)
//   out_pc           out  PC of head instruction
//   fq_count         out  occupied queue entries
// ----------------------------------------------------------------------------
module fetch_queue_unit #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INSTR_W  = 32,
    parameter int unsigned       FQ_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      stall,
    input  logic                      redirect_valid,
    input  logic [ADDR_W-1:0]         redirect_pc,
    output logic                      imem_req_valid,
    output logic [ADDR_W-1:0]         imem_req_addr,
    input  logic                      imem_req_ready,
    input  logic                      imem_resp_valid,
    input  logic [INSTR_W-1:0]        imem_resp_data,
    output logic                      out_valid,
    output logic [INSTR_W-1:0]        out_instr,
    output logic [3:0]                out_opcode,
    output logic [ADDR_W-1:0]         out_pc,
    output logic [$clog2(FQ_DEPTH):0] fq_count
);

    localparam int unsigned PTR_W = $clog2(FQ_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

`ifdef FETCH_UBR_HALT_EN
    localparam logic [3:0] OPC_UBRANCH = 4'b1100;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_DROP  = 2'd2,
        S_HALT  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_DROP  = 2'd2
    } state_t;
`endif

    state_t              state_q;
    logic [ADDR_W-1:0]   pc_q;
    logic [ADDR_W-1:0]   req_pc_q;

    // Queue storage and bookkeeping
    logic [INSTR_W-1:0]  fq_instr_q [FQ_DEPTH];
    logic [ADDR_W-1:0]   fq_pc_q    [FQ_DEPTH];
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;

    // Head register set
    logic                out_valid_q, out_valid_d;
    logic [INSTR_W-1:0]  out_instr_q, out_instr_d;
    logic [ADDR_W-1:0]   out_pc_q, out_pc_d;

    logic                full_c;
    logic                req_valid_c;
    logic                req_fire_c;
    logic                push_c;
    logic                pop_c;

    // Request/queue handshake decode
    always_comb begin
        full_c      = (count_q == CNT_W'(FQ_DEPTH));
        // Gated by reset so no request is presented while reset is held.
        req_valid_c = reset && (state_q == S_FETCH) && !full_c && !redirect_valid;
        req_fire_c  = req_valid_c && imem_req_ready;
        // A response coinciding with a redirect belongs to the squashed path.
        push_c      = (state_q == S_WAIT) && imem_resp_valid && !redirect_valid;
        pop_c       = out_valid_q && !stall && !redirect_valid;
    end

`ifdef FETCH_UBR_HALT_EN
    logic push_ubr_c;
    assign push_ubr_c = push_c && (imem_resp_data[INSTR_W-1 -: 4] == OPC_UBRANCH);
`endif

    // Fetch control FSM and PC
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
        end else if (redirect_valid) begin
            pc_q <= redirect_pc;
            case (state_q)
                // An in-flight request must still be drained unless its
                // response lands in this very cycle.
                S_WAIT, S_DROP: state_q <= imem_resp_valid ? S_FETCH : S_DROP;
                default:        state_q <= S_FETCH;
            endcase
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (req_fire_c) begin
                        pc_q     <= pc_q + ADDR_W'(4);
                        req_pc_q <= pc_q;
                        state_q  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_resp_valid) begin
`ifdef FETCH_UBR_HALT_EN
                        state_q <= push_ubr_c ? S_HALT : S_FETCH;
`else
                        state_q <= S_FETCH;
`endif
                    end
                end
                S_DROP: begin
                    if (imem_resp_valid) begin
                        state_q <= S_FETCH;
                    end
                end
                default: begin
                    // HALT leaves only through a redirect.
                    state_q <= state_q;
                end
            endcase
        end
    end

    // Queue pointer/occupancy next-state and head selection
    always_comb begin
        rd_ptr_d    = rd_ptr_q + PTR_W'(pop_c);
        wr_ptr_d    = wr_ptr_q + PTR_W'(push_c);
        count_d     = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;

        if (redirect_valid) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end

        out_valid_d = (count_d != '0);

        // The new head is either an entry already stored, or the entry being
        // written this cycle when it lands exactly at the new read pointer.
        if (out_valid_d) begin
            if (push_c && (wr_ptr_q == rd_ptr_d)) begin
                out_instr_d = imem_resp_data;
                out_pc_d    = req_pc_q;
            end else begin
                out_instr_d = fq_instr_q[rd_ptr_d];
                out_pc_d    = fq_pc_q[rd_ptr_d];
            end
        end
    end

    // Queue control and head registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_pc_q    <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
        end
    end

    // Entry storage; contents are only read once marked valid by count_q
    always_ff @(posedge clk) begin
        if (push_c) begin
            fq_instr_q[wr_ptr_q] <= imem_resp_data;
            fq_pc_q[wr_ptr_q]    <= req_pc_q;
        end
    end

    assign imem_req_valid = req_valid_c;
    assign imem_req_addr  = pc_q;
    assign out_valid      = out_valid_q;
    assign out_instr      = out_instr_q;
    assign out_opcode     = out_instr_q[INSTR_W-1 -: 4];
    assign out_pc         = out_pc_q;
    assign fq_count       = count_q;

endmodule
